// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 serial transmitter, receiver and benches.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_match_model.sv
// Reference overlapping Moore 1011 detector watching the transmitted line,
// with a saturating hit counter.
module seq_match_model
  import seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             line,
  output logic             exp_hit,
  output logic [CNT_W-1:0] exp_count
);

  logic [2:0]       hist_reg;
  logic             hit_reg;
  logic [CNT_W-1:0] count_reg;
  logic             match;

  assign match = ({hist_reg, line} == PAT_1011);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg  <= '0;
      hit_reg   <= 1'b0;
      count_reg <= '0;
    end else if (clear) begin
      hist_reg  <= '0;
      hit_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      // Idle cycles shift in 0 too, since the receiver sees the low line.
      hist_reg <= {hist_reg[1:0], line};
      hit_reg  <= match;
      if (hit_reg && (count_reg != '1)) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign exp_hit   = hit_reg;
  assign exp_count = count_reg;

endmodule

// File: rtl/moore_1011_tx.sv
// Gapless MSB-first word serializer with a one-entry hold register, plus the
// reference 1011 detector running on the driven line.
module moore_1011_tx
  import seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             exp_hit,
  output logic [CNT_W-1:0] exp_count,
  output logic             idle
);

  localparam int BW = (W > 2) ? $clog2(W) : 1;

  tx_state_t      state_reg;
  logic [W-1:0]   sh_reg;
  logic [BW-1:0]  bcnt_reg;
  logic [W-1:0]   hold_reg;
  logic           hold_full_reg;

  logic accept;
  logic last_bit;
  logic load_slot;

  assign accept    = in_valid && !hold_full_reg;
  assign last_bit  = (state_reg == SHIFT) && (bcnt_reg == BW'(W - 1));
  assign load_slot = (state_reg == IDLE) || last_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      sh_reg        <= '0;
      bcnt_reg      <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else if (load_slot && (hold_full_reg || accept)) begin
      // A waiting hold word wins; otherwise the accepted word bypasses hold.
      // in_ready is low while hold is full, so no accept can collide here.
      state_reg     <= SHIFT;
      bcnt_reg      <= '0;
      sh_reg        <= hold_full_reg ? hold_reg : in_data;
      hold_full_reg <= 1'b0;
    end else if (load_slot) begin
      // Shifter kept at zero while idle so its MSB drives the quiet line.
      state_reg <= IDLE;
      sh_reg    <= '0;
      bcnt_reg  <= '0;
    end else begin
      sh_reg   <= {sh_reg[W-2:0], 1'b0};
      bcnt_reg <= bcnt_reg + 1'b1;
      if (accept) begin
        hold_reg      <= in_data;
        hold_full_reg <= 1'b1;
      end
    end
  end

  assign in_ready   = !hold_full_reg;
  assign dout       = sh_reg[W-1];
  assign dout_valid = (state_reg == SHIFT);
  assign idle       = (state_reg == IDLE) && !hold_full_reg;

  seq_match_model #(
    .CNT_W(CNT_W)
  ) u_model (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .line     (dout),
    .exp_hit  (exp_hit),
    .exp_count(exp_count)
  );

endmodule

// File: tb/tb_moore_1011_tx.sv
// Directed bench for moore_1011_tx: full-width counter instance plus a
// CNT_W=2 instance sharing the same stimulus for the saturation case.
module tb_moore_1011_tx;
  import seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;

  logic        in_ready, dout, dout_valid, exp_hit, idle;
  logic [15:0] exp_count;
  logic        s_in_ready, s_dout, s_dout_valid, s_exp_hit, s_idle;
  logic [1:0]  s_exp_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]  wq[$];
  logic [63:0] d_vec, v_vec, r_vec, h_vec, i_vec;

  moore_1011_tx #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid), .exp_hit(exp_hit),
    .exp_count(exp_count), .idle(idle)
  );

  moore_1011_tx #(.W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .dout(s_dout), .dout_valid(s_dout_valid), .exp_hit(s_exp_hit),
    .exp_count(s_exp_count), .idle(s_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    $display("check %-14s got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Runs n cycles, feeding queued words and recording outputs, first cycle in the MSB.
  task automatic run(input int n);
    logic fire;
    d_vec = '0; v_vec = '0; r_vec = '0; h_vec = '0; i_vec = '0;
    for (int i = 0; i < n; i++) begin
      if (!in_valid && wq.size() > 0) begin
        in_valid = 1'b1;
        in_data  = wq.pop_front();
      end
      d_vec = {d_vec[62:0], dout};
      v_vec = {v_vec[62:0], dout_valid};
      r_vec = {r_vec[62:0], in_ready};
      h_vec = {h_vec[62:0], exp_hit};
      i_vec = {i_vec[62:0], idle};
      fire  = in_valid && in_ready;
      tick();
      if (fire) begin
        if (wq.size() > 0) in_data = wq.pop_front();
        else in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dout_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_count", exp_count, 0);
    tick();
    rst = 1'b1;
    tick();

    // Single word 1011_0000: MSB one cycle after accept, hit after 4th bit.
    wq.push_back(8'hB0);
    run(11);
    chk("b0_dout", d_vec, 64'b01011000000);
    chk("b0_dvalid", v_vec, 64'b01111111100);
    chk("b0_ready", r_vec, 64'b11111111111);
    chk("b0_idle", i_vec, 64'b10000000011);
    chk("b0_hit", h_vec, 64'b00000100000);
    chk("b0_count", exp_count, 1);

    // Overlapping matches inside one word.
    do_clear();
    chk("clr_count", exp_count, 0);
    wq.push_back(8'hB6);
    run(11);
    chk("b6_dout", d_vec, 64'b01011011000);
    chk("b6_hit", h_vec, 64'b00000100100);
    chk("b6_count", exp_count, 2);

    // Match straddling two back-to-back words.
    do_clear();
    wq.push_back(8'h05);
    wq.push_back(8'h80);
    run(19);
    chk("x_dout", d_vec, {1'b0, 8'h05, 8'h80, 2'b00});
    chk("x_dvalid", v_vec, {1'b0, 16'hFFFF, 2'b00});
    chk("x_ready", r_vec, {2'b11, 7'b0, 10'h3FF});
    chk("x_hit", h_vec, 64'b0000000000100000000);
    chk("x_count", exp_count, 1);

    // Backpressure with three words offered continuously.
    do_clear();
    wq.push_back(8'hA5);
    wq.push_back(8'h3C);
    wq.push_back(8'h0F);
    run(28);
    chk("bp_dout", d_vec, {1'b0, 8'hA5, 8'h3C, 8'h0F, 3'b000});
    chk("bp_dvalid", v_vec, {1'b0, 24'hFFFFFF, 3'b000});
    chk("bp_ready", r_vec, {2'b11, 7'b0, 1'b1, 7'b0, 11'h7FF});

    // Idle gap breaks the 1011; back-to-back forms it.
    do_clear();
    wq.push_back(8'h01);
    run(10);
    wq.push_back(8'h60);
    run(12);
    chk("gap_count", exp_count, 0);
    do_clear();
    wq.push_back(8'h01);
    wq.push_back(8'h60);
    run(20);
    chk("b2b_count", exp_count, 1);

    // Clear in the same cycle as a match suppresses the hit.
    do_clear();
    wq.push_back(8'hB0);
    run(4);
    chk("cm_dout", dout, 1);
    clear = 1'b1;
    run(1);
    clear = 1'b0;
    chk("cm_hit", exp_hit, 0);
    chk("cm_count", exp_count, 0);
    run(8);
    chk("cm_hit_tail", h_vec, 0);

    // Five hits: full counter reads 5, 2-bit counter saturates at 3.
    do_clear();
    wq.push_back(8'hB6);
    wq.push_back(8'hB6);
    wq.push_back(8'hB0);
    run(30);
    chk("sat_full", exp_count, 5);
    chk("sat_2bit", s_exp_count, 3);

    // Reset mid-word drops everything at once.
    wq.push_back(8'hFF);
    wq.push_back(8'hFF);
    run(4);
    chk("mid_dvalid", dout_valid, 1);
    rst = 1'b0;
    wq.delete();
    in_valid = 1'b0;
    #1;
    chk("mrst_dout", dout, 0);
    chk("mrst_dvalid", dout_valid, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_idle", idle, 1);
    chk("mrst_count", exp_count, 0);
    chk("mrst_scount", s_exp_count, 0);
    #1;
    rst = 1'b1;
    run(10);
    chk("post_dvalid", v_vec, 0);
    chk("post_dout", d_vec, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/moore_1011_tx.md
# moore_1011_tx

Serial pattern transmitter: the driving end of the `1011` serial-detector interface. It takes parallel words over a valid/ready handshake and serializes them MSB-first onto a one-bit line, one bit per clock, with no gaps between back-to-back words. It also runs a reference model of an overlapping Moore `1011` detector on the line it drives, so a bench or self-test can compare `exp_hit` and `exp_count` against the receiver.

## Interface
- `W`, default 8: word width in bits, at least 2.
- `CNT_W`, default 16: width of the match counter.

- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous clear of the match history and `exp_count`.
- `in_valid`  in  1  `in_data` is offered.
- `in_data`  in  W  word to transmit, MSB first.
- `in_ready`  out  1  a word can be accepted this cycle.
- `dout`  out  1  serial line; drives 0 when no bit is being sent.
- `dout_valid`  out  1  `dout` carries a data bit.
- `exp_hit`  out  1  one-cycle pulse where a Moore `1011` detector would assert its output.
- `exp_count`  out  CNT_W  number of `exp_hit` pulses, saturating.
- `idle`  out  1  shifter and hold register both empty.

## Operation
- **Datapath:**
  - Shifter `sh[W-1:0]` and bit counter `bcnt`.
  - One-entry hold register with a `hold_full` flag.
  - The FSM has two states, IDLE and SHIFT.
- **Handshake:**
  - `in_ready = !hold_full`.
  - A word is accepted on a rising edge where both `in_valid` and `in_ready` are high.
- **Load rules:**
  - The shifter loads when it is in IDLE, or in SHIFT on its last bit (`bcnt == W-1`).
  - A load takes the hold word if the hold register is full. Otherwise it takes the word being accepted this edge, which then bypasses the hold register.
  - An accepted word that does not go into the shifter goes into the hold register.
- **SHIFT state:**
  - `dout = sh[W-1]` and `dout_valid = 1`.
  - Each edge shifts left by one and increments `bcnt`.
  - After the last bit, the FSM reloads if a word is available; otherwise it returns to IDLE.
- **IDLE state:** `dout = 0`, `dout_valid = 0`.
- **Reference model:**
  - A 3-bit history `hist` shifts in `dout` every cycle, including idle cycles, because the line carries 0 then and the receiver sees it.
  - A match is `{hist, dout} == 4'b1011`. Matches may overlap.
  - `exp_hit` is the registered match.
  - `exp_count` increments when `exp_hit` is high and holds at all-ones once saturated.
- **Clear:**
  - `clear` zeroes `hist`, `exp_hit` and `exp_count` on the next edge.
  - `clear` takes priority over a match in the same cycle.
  - The datapath is unaffected.

## Timing
- **Reset values:**
  - `dout`, `dout_valid`, `exp_hit`, `exp_count` are all 0.
  - `in_ready = 1`, `idle = 1`.
  - Internal state: `hist = 0`, FSM in IDLE, hold register empty.
- **Latency:** a word accepted at edge k drives its MSB on `dout` in cycle k+1 when the shifter is free.
- **Streaming:**
  - A word accepted at or before the last-bit edge of the current word starts on the next cycle with no gap.
  - Sustained throughput is one word per W cycles.
- **`exp_hit` timing:** the pulse is high in the cycle after the final `1` of a `1011` is on `dout`. This matches the Moore output delay.
- **Boundary conditions:**
  - *Hold full with shifter busy:* `in_ready` is 0 and offered words are not accepted. `in_ready` returns to 1 the cycle after the hold word moves into the shifter.
  - *Accept on the last-bit edge with the hold register empty:* the word bypasses the hold register; `in_ready` stays 1.
  - *Reset mid-word:* the word in flight and the hold word are discarded, and `dout` drops to 0 immediately.
  - *W=2:* the load rules are the same.

## Structure
- Shared package `seq_pkg`:
  - the FSM state enum (IDLE, SHIFT);
  - the constant `PAT_1011 = 4'b1011`, reused by the receiver and the benches.
- One natural sub-module, `seq_match_model`:
  - contains the history register, matcher and saturating counter;
  - inputs are `clk`, `rst`, `clear` and the line bit;
  - outputs are `exp_hit` and `exp_count`.
- The top level holds the handshake, hold register, shifter and FSM.

## Test plan
- **Reset:** assert `rst=0` mid-stream -> `dout=0`, `dout_valid=0`, `in_ready=1`, `idle=1`, `exp_count=0` at once.
- **Single word:** send `8'b1011_0000` -> `dout` is 1,0,1,1,0,0,0,0 in cycles k+1 through k+8; one `exp_hit` in cycle k+5; `exp_count=1`.
- **Overlap and cross-word match:**
  - `8'hB6` sent alone -> two hits.
  - `8'h05` then `8'h80` back-to-back -> 16 continuous `dout_valid` cycles and one hit, in the cycle after the first bit of the second word.
- **Backpressure:** hold `in_valid` high with 3 words -> `in_ready` falls after the second accept and rises when word 2 enters the shifter; the output is gapless and in order.
- **Idle gap:** `8'h01`, then 2 idle cycles, then `8'h60` -> `exp_count=0`. The same two words back-to-back -> `exp_count=1`.
- **Clear and saturation:**
  - `clear` in the same cycle as a match -> `exp_hit=0`, `exp_count=0`.
  - With `CNT_W=2`, five hits -> `exp_count=3`.
